// File: rtl/asm_il_sched.sv
// Two-bank ping-pong frame scheduler for the ASM interleaver (link IDs 4-7).
// Define ASM_SCHED_TIMEOUT_EN to add the write-side idle watchdog.
module asm_il_sched #(
  parameter int ADDRESS = 16,
  parameter int LEN_W   = 13,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sof,
  input  logic [1:0]         link_sel,
  input  logic               din_vld,
  output logic               din_rdy,
  output logic               wen,
  output logic               wr_bank,
  output logic [ADDRESS-1:0] wr_addr,
  input  logic               request,
  output logic               rd_start,
  output logic               rd_bank,
  output logic [ADDRESS-1:0] rd_addr,
  output logic [ADDRESS-1:0] id_offset,
  output logic [LEN_W-1:0]   m_len,
  output logic               dout_vld,
  output logic               frame_done,
  output logic               err
);
  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ARM, R_DRAIN} r_state_t;

  w_state_t           w_state_reg, w_state_next;
  r_state_t           r_state_reg;
  logic [1:0]         full_reg, full_next;
  logic               wr_ptr_reg, wr_ptr_next;
  logic               rd_ptr_reg;
  logic               din_rdy_reg, din_rdy_next;
  logic [LEN_W-1:0]   wr_idx_reg, rd_idx_reg;
  logic [LEN_W-1:0]   desc_len_reg [2];
  logic [ADDRESS-1:0] desc_off_reg [2];
  logic [LEN_W-1:0]   lut_len;
  logic [ADDRESS-1:0] lut_off;
  logic               sof_acc, wr_last, rd_last, abort;

  logic               wen_reg, wr_bank_reg, err_reg;
  logic [ADDRESS-1:0] wr_addr_reg;
  logic               rd_start_reg, rd_bank_reg, issue_reg, dout_vld_reg, frame_done_reg;
  logic [ADDRESS-1:0] rd_addr_reg, id_offset_reg;
  logic [LEN_W-1:0]   m_len_reg;

  always_comb begin
    lut_len = LEN_W'(952);
    lut_off = ADDRESS'(0);
    case (link_sel)
      2'd0: begin lut_len = LEN_W'(952);  lut_off = ADDRESS'(0);    end
      2'd1: begin lut_len = LEN_W'(288);  lut_off = ADDRESS'(960);  end
      2'd2: begin lut_len = LEN_W'(672);  lut_off = ADDRESS'(1248); end
      default: begin lut_len = LEN_W'(1056); lut_off = ADDRESS'(1920); end
    endcase
  end

  assign sof_acc = (w_state_reg == W_IDLE) && sof && din_rdy_reg;
  assign wr_last = (w_state_reg == W_FILL) && din_vld &&
                   (wr_idx_reg == desc_len_reg[wr_ptr_reg] - LEN_W'(1));
  assign rd_last = (r_state_reg == R_DRAIN) && request &&
                   (rd_idx_reg == m_len_reg - LEN_W'(1));

`ifdef ASM_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt_reg;

  assign abort = (w_state_reg == W_FILL) && !din_vld && (idle_cnt_reg == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || (w_state_reg != W_FILL) || din_vld) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign abort = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Set and clear of full always hit different banks, so both apply.
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: if (sof_acc) w_state_next = W_FILL;
      W_FILL: if (wr_last || abort) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
    full_next = full_reg;
    if (wr_last) full_next[wr_ptr_reg] = 1'b1;
    if (rd_last) full_next[rd_ptr_reg] = 1'b0;
    wr_ptr_next  = wr_ptr_reg ^ wr_last;
    din_rdy_next = (w_state_next == W_FILL) || !full_next[wr_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      full_reg    <= '0;
      wr_ptr_reg  <= 1'b0;
      din_rdy_reg <= 1'b0;
      wr_idx_reg  <= '0;
      wen_reg     <= 1'b0;
      wr_bank_reg <= 1'b0;
      wr_addr_reg <= '0;
      err_reg     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        desc_len_reg[i] <= '0;
        desc_off_reg[i] <= '0;
      end
    end else begin
      w_state_reg <= w_state_next;
      full_reg    <= full_next;
      wr_ptr_reg  <= wr_ptr_next;
      din_rdy_reg <= din_rdy_next;
      wen_reg     <= 1'b0;
      err_reg     <= abort;
      case (w_state_reg)
        W_IDLE: begin
          if (sof_acc) begin
            desc_len_reg[wr_ptr_reg] <= lut_len;
            desc_off_reg[wr_ptr_reg] <= lut_off;
            wr_idx_reg <= din_vld ? LEN_W'(1) : '0;
            if (din_vld) begin
              wen_reg     <= 1'b1;
              wr_addr_reg <= lut_off;
              wr_bank_reg <= wr_ptr_reg;
            end
          end else if (sof || din_vld) begin
            err_reg <= 1'b1;
          end
        end
        W_FILL: begin
          if (sof) err_reg <= 1'b1;
          if (din_vld) begin
            wen_reg     <= 1'b1;
            wr_addr_reg <= desc_off_reg[wr_ptr_reg] + ADDRESS'(wr_idx_reg);
            wr_bank_reg <= wr_ptr_reg;
            wr_idx_reg  <= wr_idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read side: rd_bank/id_offset/m_len are latched at arm time so they stay
  // aligned with rd_addr even after the internal pointer flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg    <= R_IDLE;
      rd_ptr_reg     <= 1'b0;
      rd_idx_reg     <= '0;
      rd_start_reg   <= 1'b0;
      rd_bank_reg    <= 1'b0;
      rd_addr_reg    <= '0;
      id_offset_reg  <= '0;
      m_len_reg      <= '0;
      issue_reg      <= 1'b0;
      dout_vld_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      rd_start_reg   <= 1'b0;
      issue_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      dout_vld_reg   <= issue_reg;
      case (r_state_reg)
        R_IDLE: begin
          if (full_reg[rd_ptr_reg]) begin
            r_state_reg   <= R_ARM;
            rd_start_reg  <= 1'b1;
            id_offset_reg <= desc_off_reg[rd_ptr_reg];
            m_len_reg     <= desc_len_reg[rd_ptr_reg];
            rd_bank_reg   <= rd_ptr_reg;
            rd_idx_reg    <= '0;
          end
        end
        R_ARM: r_state_reg <= R_DRAIN;
        R_DRAIN: begin
          if (request) begin
            issue_reg   <= 1'b1;
            rd_addr_reg <= id_offset_reg + ADDRESS'(rd_idx_reg);
            rd_idx_reg  <= rd_idx_reg + 1'b1;
            if (rd_last) begin
              frame_done_reg <= 1'b1;
              rd_ptr_reg     <= ~rd_ptr_reg;
              r_state_reg    <= R_IDLE;
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign din_rdy    = din_rdy_reg;
  assign wen        = wen_reg;
  assign wr_bank    = wr_bank_reg;
  assign wr_addr    = wr_addr_reg;
  assign err        = err_reg;
  assign rd_start   = rd_start_reg;
  assign rd_bank    = rd_bank_reg;
  assign rd_addr    = rd_addr_reg;
  assign id_offset  = id_offset_reg;
  assign m_len      = m_len_reg;
  assign dout_vld   = dout_vld_reg;
  assign frame_done = frame_done_reg;
endmodule
